// File: rtl/user_mgr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// user_mgr_arbiter_pkg
// Purpose : shared constants and OBI manager-port types for the user manager
//           arbiter and its index FIFO.
// Contents: UserMgrArbNumReq / UserMgrArbMaxTrans defaults, OBI A-phase and
//           R-phase structs, arbiter lock state enum.
// ---------------------------------------------------------------------------
package user_mgr_arbiter_pkg;

    localparam int unsigned UserMgrArbNumReq   = 2;
    localparam int unsigned UserMgrArbMaxTrans = 2;

    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;
    localparam int unsigned ObiIdWidth   = 3;

    typedef struct packed {
        logic [ObiAddrWidth-1:0]   addr;
        logic                      we;
        logic [ObiDataWidth/8-1:0] be;
        logic [ObiDataWidth-1:0]   wdata;
        logic [ObiIdWidth-1:0]     aid;
    } mgr_obi_a_chan_t;

    typedef struct packed {
        mgr_obi_a_chan_t a;
        logic            req;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic                    err;
        logic [ObiIdWidth-1:0]   rid;
    } mgr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        mgr_obi_r_chan_t r;
    } mgr_obi_rsp_t;

    typedef enum logic {
        ArbIdle   = 1'b0,
        ArbLocked = 1'b1
    } arb_state_e;

endpackage

// File: rtl/user_mgr_arb_fifo.sv
// ---------------------------------------------------------------------------
// user_mgr_arb_fifo
// Purpose : in-order FIFO of granted requester indices, one entry per
//           outstanding transaction on the shared manager port.
// Ports   : i_clk, i_rst (async, active-high)
//           i_push / i_data : store the index of a just-accepted handshake
//           i_pop           : drop the head when its response arrives
//           o_head          : index owning the oldest outstanding transaction
//           o_count         : number of outstanding transactions
// ---------------------------------------------------------------------------
module user_mgr_arb_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [Width-1:0]           i_data,
    input  logic                       i_pop,
    output logic [Width-1:0]           o_head,
    output logic [$clog2(Depth+1)-1:0] o_count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_count;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // The arbiter never pushes while full and never pops while empty.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= ptr_inc(r_wptr);
            if (i_pop)  r_rptr <= ptr_inc(r_rptr);
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (i_pop && !i_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/user_mgr_arbiter.sv
// ---------------------------------------------------------------------------
// user_mgr_arbiter
// Purpose : round-robin arbiter sharing one OBI manager port between NumReq
//           requesters, with A-phase lock while a request waits for gnt and
//           in-order response routing through an index FIFO.
// Ports   : clk_i, rst_i (async, active-high)
//           req_i / rsp_o         : per-requester OBI A-phase in, gnt/R out
//           mgr_req_o / mgr_rsp_i : shared OBI port towards the subordinate
//           busy_o                : outstanding transaction or request active
//           spurious_o            : pulse on rvalid with nothing outstanding
//
// state     | meaning
// ArbIdle   | free round-robin selection from the pointer
// ArbLocked | request presented without gnt; selection held on r_lock_idx
// ---------------------------------------------------------------------------
module user_mgr_arbiter
    import user_mgr_arbiter_pkg::*;
#(
    parameter int unsigned NumReq   = UserMgrArbNumReq,
    parameter int unsigned MaxTrans = UserMgrArbMaxTrans
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  mgr_obi_req_t req_i [NumReq],
    output mgr_obi_rsp_t rsp_o [NumReq],
    output mgr_obi_req_t mgr_req_o,
    input  mgr_obi_rsp_t mgr_rsp_i,
    output logic         busy_o,
    output logic         spurious_o
);

    localparam int unsigned SelW = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(MaxTrans + 1);

    arb_state_e      r_state;
    arb_state_e      w_state_next;
    logic [SelW-1:0] r_ptr;
    logic [SelW-1:0] r_lock_idx;

    logic [NumReq-1:0] w_req_vec;
    logic [SelW-1:0]   w_sel;
    logic [SelW-1:0]   w_head;
    logic [CntW-1:0]   w_count;
    logic              w_full;
    logic              w_mgr_req;
    logic              w_push;
    logic              w_pop;

    // Lowest requesting index at or above ptr, wrapping; ptr if none request.
    function automatic logic [SelW-1:0] rr_pick(input logic [NumReq-1:0] reqs,
                                                 input logic [SelW-1:0]   ptr);
        logic [SelW-1:0] pick;
        logic            found;
        int              j;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            j = (int'(ptr) + k) % NumReq;
            if (!found && reqs[j]) begin
                pick  = SelW'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        w_req_vec = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_req_vec[i] = req_i[i].req;
        end
    end

    // During reset the A-phase mirrors requester 0 with req suppressed.
    always_comb begin
        if (rst_i) begin
            w_sel = '0;
        end else if (r_state == ArbLocked) begin
            w_sel = r_lock_idx;
        end else begin
            w_sel = rr_pick(w_req_vec, r_ptr);
        end
    end

    // Full is judged on the registered count, so a same-cycle pop cannot
    // free a slot for a grant until the next cycle.
    assign w_full    = (w_count == CntW'(MaxTrans));
    assign w_mgr_req = !rst_i && req_i[w_sel].req && !w_full;
    assign w_push    = w_mgr_req && mgr_rsp_i.gnt;
    assign w_pop     = mgr_rsp_i.rvalid && (w_count != '0);

    always_comb begin
        w_state_next = ArbIdle;
        if (w_mgr_req && !mgr_rsp_i.gnt) begin
            w_state_next = ArbLocked;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ArbIdle;
            r_lock_idx <= '0;
            r_ptr      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == ArbLocked) begin
                r_lock_idx <= w_sel;
            end
            if (w_push) begin
                r_ptr <= (w_sel == SelW'(NumReq - 1)) ? '0 : w_sel + 1'b1;
            end
        end
    end

    user_mgr_arb_fifo #(
        .Width (SelW),
        .Depth (MaxTrans)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push),
        .i_data  (w_sel),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_comb begin
        mgr_req_o.a   = req_i[w_sel].a;
        mgr_req_o.req = w_mgr_req;
    end

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            rsp_o[i].gnt    = w_push && (w_sel == SelW'(i));
            rsp_o[i].rvalid = w_pop && (w_head == SelW'(i));
            rsp_o[i].r      = mgr_rsp_i.r;
        end
    end

    assign busy_o     = (w_count != '0) || w_mgr_req;
    assign spurious_o = !rst_i && mgr_rsp_i.rvalid && (w_count == '0);

endmodule

// File: tb/tb_user_mgr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_user_mgr_arbiter
// Purpose : self-checking bench for user_mgr_arbiter. A queue-based model of
//           outstanding transactions predicts every output each cycle;
//           directed scenarios plus a randomized phase drive the DUT.
// ---------------------------------------------------------------------------
module tb_user_mgr_arbiter;
    import user_mgr_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int MT = 2;

    logic         clk = 1'b0;
    logic         rst;
    mgr_obi_req_t req_i [NR];
    mgr_obi_rsp_t rsp_o [NR];
    mgr_obi_req_t mgr_req_o;
    mgr_obi_rsp_t mgr_rsp_i;
    logic         busy_o;
    logic         spurious_o;

    always #5 clk = ~clk;

    user_mgr_arbiter #(
        .NumReq   (NR),
        .MaxTrans (MT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req_i),
        .rsp_o      (rsp_o),
        .mgr_req_o  (mgr_req_o),
        .mgr_rsp_i  (mgr_rsp_i),
        .busy_o     (busy_o),
        .spurious_o (spurious_o)
    );

    int checks = 0;
    int errors = 0;

    // reference model: outstanding owners in issue order, rr pointer, lock
    int q_idx[$];
    int m_ptr      = 0;
    bit m_lock     = 1'b0;
    int m_lock_idx = 0;

    // stimulus environment
    int due[$];
    int last_due  = -1;
    int cyc       = 0;
    int rem[NR];
    int gnt_mode  = 0;   // 0 always, 1 never, 2 random
    int lat       = 1;
    bit rand_mode = 1'b0;
    bit fixed_a1  = 1'b0;

    // observed DUT history
    int o_gnt_idx[$];
    int o_gnt_cyc[$];
    int o_rv_idx[$];
    int o_rv_cyc[$];
    int o_spur = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a();
        for (int i = 0; i < NR; i++) begin
            if (fixed_a1 && i == 1) begin
                req_i[i].a.addr  = 32'h2000_0000;
                req_i[i].a.we    = 1'b1;
                req_i[i].a.be    = 4'hF;
                req_i[i].a.wdata = 32'hDEAD_BEEF;
                req_i[i].a.aid   = 3'd0;
            end else begin
                req_i[i].a.addr  = $urandom;
                req_i[i].a.we    = 1'($urandom_range(0, 1));
                req_i[i].a.be    = 4'($urandom);
                req_i[i].a.wdata = $urandom;
                req_i[i].a.aid   = 3'($urandom);
            end
        end
    endtask

    task automatic drive_r(input bit g, input bit rv);
        mgr_rsp_i.gnt     = g;
        mgr_rsp_i.rvalid  = rv;
        mgr_rsp_i.r.rdata = $urandom;
        mgr_rsp_i.r.err   = 1'($urandom_range(0, 1));
        mgr_rsp_i.r.rid   = 3'($urandom);
    endtask

    task automatic step();
        logic [NR-1:0]   r;
        logic [NR-1:0]   exp_gnt;
        logic [NR-1:0]   exp_rv;
        logic [NR-1:0]   obs_gnt;
        logic [NR-1:0]   obs_rv;
        mgr_obi_r_chan_t rd;
        bit g, rv, full, mreq, hs, pop, spur, busy, found;
        int sel, j, d;
        @(negedge clk);
        rst = 1'b0;
        drive_a();
        for (int i = 0; i < NR; i++) begin
            r[i] = rand_mode ? ($urandom_range(0, 2) != 0) : (rem[i] > 0);
            req_i[i].req = r[i];
        end
        case (gnt_mode)
            0:       g = 1'b1;
            1:       g = 1'b0;
            default: g = ($urandom_range(0, 9) < 7);
        endcase
        rv = 1'b0;
        if (due.size() > 0 && due[0] == cyc) begin
            rv = 1'b1;
            void'(due.pop_front());
        end else if (rand_mode && due.size() == 0 && q_idx.size() == 0 && $urandom_range(0, 7) == 0) begin
            rv = 1'b1;
        end
        drive_r(g, rv);
        rd = mgr_rsp_i.r;
        #1;
        full = (q_idx.size() == MT);
        if (m_lock) begin
            sel = m_lock_idx;
        end else begin
            sel   = m_ptr;
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                j = (m_ptr + k) % NR;
                if (!found && r[j]) begin
                    sel   = j;
                    found = 1'b1;
                end
            end
        end
        mreq = r[sel] && !full;
        hs   = mreq && g;
        pop  = rv && (q_idx.size() > 0);
        spur = rv && (q_idx.size() == 0);
        busy = (q_idx.size() > 0) || mreq;
        exp_gnt = '0;
        exp_rv  = '0;
        if (hs)  exp_gnt[sel]      = 1'b1;
        if (pop) exp_rv[q_idx[0]]  = 1'b1;
        for (int i = 0; i < NR; i++) begin
            obs_gnt[i] = rsp_o[i].gnt;
            obs_rv[i]  = rsp_o[i].rvalid;
            if (rsp_o[i].gnt === 1'b1) begin
                o_gnt_idx.push_back(i);
                o_gnt_cyc.push_back(cyc);
            end
            if (rsp_o[i].rvalid === 1'b1) begin
                o_rv_idx.push_back(i);
                o_rv_cyc.push_back(cyc);
            end
        end
        if (spurious_o === 1'b1) o_spur++;
        chk("mgr_req", 128'(mgr_req_o.req), 128'(mreq));
        chk("gnt_vec", 128'(obs_gnt), 128'(exp_gnt));
        chk("rvalid_vec", 128'(obs_rv), 128'(exp_rv));
        chk("spurious", 128'(spurious_o), 128'(spur));
        chk("busy", 128'(busy_o), 128'(busy));
        chk("r_pass0", 128'(rsp_o[0].r), 128'(rd));
        chk("r_pass_last", 128'(rsp_o[NR-1].r), 128'(rd));
        if (mreq) chk("a_phase", 128'(mgr_req_o.a), 128'(req_i[sel].a));
        if (pop) void'(q_idx.pop_front());
        if (hs) begin
            q_idx.push_back(sel);
            m_ptr = (sel + 1) % NR;
            if (rem[sel] > 0) rem[sel]--;
            d = cyc + (rand_mode ? int'($urandom_range(1, 4)) : lat);
            if (d <= last_due) d = last_due + 1;
            due.push_back(d);
            last_due = d;
        end
        m_lock     = mreq && !g;
        m_lock_idx = sel;
        cyc++;
    endtask

    task automatic do_reset();
        logic [NR-1:0] obs_gnt;
        logic [NR-1:0] obs_rv;
        bit rv;
        @(negedge clk);
        rst = 1'b1;
        drive_a();
        for (int i = 0; i < NR; i++) req_i[i].req = 1'b1;
        rv = 1'b1;
        if (due.size() > 0 && due[0] == cyc) void'(due.pop_front());
        drive_r(1'b1, rv);
        #1;
        for (int i = 0; i < NR; i++) begin
            obs_gnt[i] = rsp_o[i].gnt;
            obs_rv[i]  = rsp_o[i].rvalid;
        end
        chk("rst_mgr_req", 128'(mgr_req_o.req), 128'(0));
        chk("rst_a_from_req0", 128'(mgr_req_o.a), 128'(req_i[0].a));
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_spurious", 128'(spurious_o), 128'(0));
        chk("rst_gnt_vec", 128'(obs_gnt), 128'(0));
        chk("rst_rvalid_vec", 128'(obs_rv), 128'(0));
        q_idx.delete();
        m_ptr      = 0;
        m_lock     = 1'b0;
        m_lock_idx = 0;
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        for (int i = 0; i < NR; i++) rem[i] = 0;
        while ((q_idx.size() > 0 || due.size() > 0) && n < 60) begin
            step();
            n++;
        end
        chk("drain_bound", 128'(n < 60), 128'(1));
    endtask

    initial begin
        int b_g, b_r, b_s, n, c0;
        rst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            req_i[i] = '0;
            rem[i]   = 0;
        end
        mgr_rsp_i = '0;
        do_reset();

        // single requester 1: write DEADBEEF, gnt same cycle, rvalid next
        b_g = o_gnt_idx.size();
        b_r = o_rv_idx.size();
        gnt_mode = 0;
        lat      = 1;
        fixed_a1 = 1'b1;
        rem      = '{0, 1};
        step();
        chk("single_a_wdata", 128'(mgr_req_o.a.wdata), 128'(32'hDEAD_BEEF));
        step();
        fixed_a1 = 1'b0;
        chk("single_gnt_cnt", 128'(o_gnt_idx.size() - b_g), 128'(1));
        chk("single_rv_cnt", 128'(o_rv_idx.size() - b_r), 128'(1));
        if (o_gnt_idx.size() > b_g && o_rv_idx.size() > b_r) begin
            chk("single_gnt_idx", 128'(o_gnt_idx[b_g]), 128'(1));
            chk("single_rv_idx", 128'(o_rv_idx[b_r]), 128'(1));
            chk("single_latency", 128'(o_rv_cyc[b_r] - o_gnt_cyc[b_g]), 128'(1));
        end
        drain();

        // fairness: both hold req for 8 handshakes
        b_g = o_gnt_idx.size();
        rem = '{4, 4};
        n = 0;
        while ((rem[0] > 0 || rem[1] > 0) && n < 30) begin
            step();
            n++;
        end
        chk("fair_total", 128'(o_gnt_idx.size() - b_g), 128'(8));
        for (int k = 0; k < 8; k++) begin
            if (b_g + k < o_gnt_idx.size()) chk("fair_alternate", 128'(o_gnt_idx[b_g + k]), 128'(k % 2));
        end
        drain();

        // full: third grant waits for the first response
        b_g = o_gnt_idx.size();
        b_r = o_rv_idx.size();
        lat = 5;
        rem = '{2, 1};
        repeat (14) step();
        chk("full_gnt_cnt", 128'(o_gnt_idx.size() - b_g), 128'(3));
        chk("full_rv_cnt", 128'(o_rv_idx.size() - b_r), 128'(3));
        if (o_gnt_idx.size() - b_g == 3 && o_rv_idx.size() - b_r == 3) begin
            c0 = o_gnt_cyc[b_g];
            chk("full_gnt_order0", 128'(o_gnt_idx[b_g]), 128'(0));
            chk("full_gnt_order1", 128'(o_gnt_idx[b_g + 1]), 128'(1));
            chk("full_gnt_order2", 128'(o_gnt_idx[b_g + 2]), 128'(0));
            chk("full_first_rv", 128'(o_rv_cyc[b_r] - c0), 128'(5));
            chk("full_third_gnt", 128'(o_gnt_cyc[b_g + 2] - o_rv_cyc[b_r]), 128'(1));
            chk("full_rv_order0", 128'(o_rv_idx[b_r]), 128'(0));
            chk("full_rv_order1", 128'(o_rv_idx[b_r + 1]), 128'(1));
            chk("full_rv_order2", 128'(o_rv_idx[b_r + 2]), 128'(0));
        end
        drain();

        // lock: pointer now at 1, requester 0 waits 3 cycles while 1 rises
        b_g = o_gnt_idx.size();
        lat = 1;
        gnt_mode = 1;
        rem = '{1, 0};
        step();
        rem[1] = 1;
        step();
        step();
        gnt_mode = 0;
        step();
        step();
        chk("lock_gnt_cnt", 128'(o_gnt_idx.size() - b_g), 128'(2));
        if (o_gnt_idx.size() - b_g == 2) begin
            chk("lock_first", 128'(o_gnt_idx[b_g]), 128'(0));
            chk("lock_second", 128'(o_gnt_idx[b_g + 1]), 128'(1));
        end
        drain();

        // reset with two outstanding; their responses become spurious
        lat = 10;
        rem = '{1, 1};
        step();
        step();
        do_reset();
        b_s = o_spur;
        b_r = o_rv_idx.size();
        drain();
        chk("spur_pulses", 128'(o_spur - b_s), 128'(2));
        chk("spur_no_rvalid", 128'(o_rv_idx.size() - b_r), 128'(0));
        chk("spur_idle_busy", 128'(busy_o), 128'(0));

        // randomized traffic with occasional resets
        rand_mode = 1'b1;
        gnt_mode  = 2;
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else step();
        end
        rand_mode = 1'b0;
        gnt_mode  = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
